// File: rtl/ram_port_arbiter.sv
// Two-port arbiter/sequencer for a single-ported 64x16 RAM: grants one requester,
// runs its write or READ_LAT-cycle read on the RAM pins, returns read data with a done pulse.
module ram_port_arbiter #(
    parameter int READ_LAT   = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [5:0]  addr0,
    input  logic [5:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [15:0] rdata,
    output logic [5:0]  address_to_ram,
    output logic        write_enable_to_ram,
    output logic        read_enable_to_ram,
    inout  wire  [15:0] data_ram
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 1);

    state_t      state_q, state_d;
    logic        id_q, id_d;
    logic        we_q, we_d;
    logic [5:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        last_q, last_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [5:0]  ram_addr_q, ram_addr_d;
    logic        ram_we_q, ram_we_d;
    logic        ram_re_q, ram_re_d;
    logic        drive_q, drive_d;
    logic        win;

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;

        // On a tie the port that was not granted last wins, unless port 0 is fixed-priority.
        case (req)
            2'b10:   win = 1'b1;
            2'b11:   win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
            default: win = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    id_d    = win;
                    we_d    = we[win];
                    addr_d  = win ? addr1 : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                    last_d  = win;
                    cnt_d   = LAT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else if (cnt_q == 3'd0) begin
                    rdata_d = data_ram;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next state so they are registered with it.
        gnt_d      = (state_d != IDLE) ? (id_d ? 2'b10 : 2'b01) : 2'b00;
        done_d     = (state_d == DONE) ? (id_d ? 2'b10 : 2'b01) : 2'b00;
        ram_we_d   = (state_d == ACCESS) && we_d;
        ram_re_d   = (state_d == ACCESS) && !we_d;
        drive_d    = (state_d == ACCESS) && we_d;
        ram_addr_d = (state_d == ACCESS) ? addr_d : ram_addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            id_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 6'd0;
            wdata_q    <= 16'h0000;
            last_q     <= 1'b1;
            cnt_q      <= 3'd0;
            rdata_q    <= 16'h0000;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            ram_addr_q <= 6'd0;
            ram_we_q   <= 1'b0;
            ram_re_q   <= 1'b0;
            drive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
            ram_re_q   <= ram_re_d;
            drive_q    <= drive_d;
        end
    end

    assign gnt                 = gnt_q;
    assign done                = done_q;
    assign rdata               = rdata_q;
    assign address_to_ram      = ram_addr_q;
    assign write_enable_to_ram = ram_we_q;
    assign read_enable_to_ram  = ram_re_q;
    assign data_ram            = drive_q ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: instance 0 round-robin with READ_LAT=3, instance 1 fixed
// priority with READ_LAT=4, each with a behavioural RAM on its bus and a pull-up on idle bits.
module tb_ram_port_arbiter;

    localparam int RL0 = 3;
    localparam int RL1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst_s;
    logic [1:0][1:0]   req_s, we_s;
    logic [1:0][5:0]   a0_s, a1_s;
    logic [1:0][15:0]  w0_s, w1_s;
    wire  [1:0][1:0]   gnt_w, done_w;
    wire  [1:0][15:0]  rdata_w;
    wire  [1:0][5:0]   ram_a_w;
    wire  [1:0]        ram_we_w, ram_re_w;
    wire  [15:0]       bus0, bus1;
    wire  [1:0][15:0]  bus_v = {bus1, bus0};

    int n_cmp = 0;
    int n_bad = 0;

    ram_port_arbiter #(.READ_LAT(RL0), .FIXED_PRIO(0)) dut0 (
        .clk(clk), .reset(rst_s[0]), .req(req_s[0]), .we(we_s[0]),
        .addr0(a0_s[0]), .addr1(a1_s[0]), .wdata0(w0_s[0]), .wdata1(w1_s[0]),
        .gnt(gnt_w[0]), .done(done_w[0]), .rdata(rdata_w[0]),
        .address_to_ram(ram_a_w[0]), .write_enable_to_ram(ram_we_w[0]),
        .read_enable_to_ram(ram_re_w[0]), .data_ram(bus0)
    );

    ram_port_arbiter #(.READ_LAT(RL1), .FIXED_PRIO(1)) dut1 (
        .clk(clk), .reset(rst_s[1]), .req(req_s[1]), .we(we_s[1]),
        .addr0(a0_s[1]), .addr1(a1_s[1]), .wdata0(w0_s[1]), .wdata1(w1_s[1]),
        .gnt(gnt_w[1]), .done(done_w[1]), .rdata(rdata_w[1]),
        .address_to_ram(ram_a_w[1]), .write_enable_to_ram(ram_we_w[1]),
        .read_enable_to_ram(ram_re_w[1]), .data_ram(bus1)
    );

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pull
            pullup pu0 (bus0[gi]);
            pullup pu1 (bus1[gi]);
        end
    endgenerate

    // RAM model: data appears only in the last read-enable cycle, DEAD before that.
    logic [15:0] ram_mem [2][64];
    bit          ram_wr  [2][64];
    int unsigned re_cnt  [2];

    function automatic logic [15:0] init_word(logic [5:0] a);
        return (a == 6'h3F) ? 16'h1234 : {a, ~a, 4'h6};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_we_w[k]) begin
                ram_mem[k][ram_a_w[k]] <= bus_v[k];
                ram_wr[k][ram_a_w[k]]  <= 1'b1;
            end
            re_cnt[k] <= ram_re_w[k] ? re_cnt[k] + 1 : 0;
        end
    end

    assign bus0 = ram_re_w[0] ? ((re_cnt[0] == RL0 - 1) ?
                  (ram_wr[0][ram_a_w[0]] ? ram_mem[0][ram_a_w[0]] : init_word(ram_a_w[0])) : 16'hDEAD)
                  : 16'hzzzz;
    assign bus1 = ram_re_w[1] ? ((re_cnt[1] == RL1 - 1) ?
                  (ram_wr[1][ram_a_w[1]] ? ram_mem[1][ram_a_w[1]] : init_word(ram_a_w[1])) : 16'hDEAD)
                  : 16'hzzzz;

    // Reference model: memory contents, last granted port, last read data per instance.
    logic [15:0] m_mem [2][64];
    int          m_last [2];
    logic [15:0] m_rdata [2];

    function automatic int pick(int k, logic [1:0] mask);
        if (mask == 2'b01) return 0;
        if (mask == 2'b10) return 1;
        if (k == 1) return 0;
        return (m_last[k] == 0) ? 1 : 0;
    endfunction

    function automatic logic [1:0] oh(int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int rl(int k);
        return (k == 1) ? RL1 : RL0;
    endfunction

    task automatic test_reset();
        rst_s = 2'b00; req_s = '0; we_s = '0; a0_s = '0; a1_s = '0; w0_s = '0; w1_s = '0;
        @(negedge clk); @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({gnt_w[k], done_w[k], rdata_w[k], ram_a_w[k], ram_we_w[k], ram_re_w[k]} !== 30'h0) begin
                n_bad++;
                $display("FAIL reset_outputs k=%0d got gnt=%b done=%b rdata=%h addr=%h we=%b re=%b exp all 0",
                         k, gnt_w[k], done_w[k], rdata_w[k], ram_a_w[k], ram_we_w[k], ram_re_w[k]);
            end
            n_cmp++;
            if (bus_v[k] !== 16'hFFFF) begin
                n_bad++;
                $display("FAIL reset_bus k=%0d got %h exp undriven(FFFF)", k, bus_v[k]);
            end
        end
        rst_s = 2'b11;
        req_s[0] = 2'b01; we_s[0] = 2'b01; a0_s[0] = 6'h05; w0_s[0] = 16'hBEEF;
        @(negedge clk);
        n_cmp++;
        if ({gnt_w[0], done_w[0], ram_we_w[0], ram_re_w[0], ram_a_w[0]} !== {2'b01, 2'b00, 1'b1, 1'b0, 6'h05}) begin
            n_bad++;
            $display("FAIL first_write_access got gnt=%b done=%b we=%b re=%b addr=%h exp 01 00 1 0 05",
                     gnt_w[0], done_w[0], ram_we_w[0], ram_re_w[0], ram_a_w[0]);
        end
        n_cmp++;
        if (bus0 !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL first_write_bus got %h exp BEEF", bus0);
        end
        @(negedge clk);
        n_cmp++;
        if ({gnt_w[0], done_w[0], ram_we_w[0], bus0} !== {2'b01, 2'b01, 1'b0, 16'hFFFF}) begin
            n_bad++;
            $display("FAIL first_write_done got gnt=%b done=%b we=%b bus=%h exp 01 01 0 FFFF",
                     gnt_w[0], done_w[0], ram_we_w[0], bus0);
        end
        req_s[0] = 2'b00;
        m_mem[0][5] = 16'hBEEF; m_last[0] = 0;
        @(negedge clk);
        n_cmp++;
        if ({gnt_w[0], done_w[0]} !== 4'b0000) begin
            n_bad++;
            $display("FAIL first_write_idle got gnt=%b done=%b exp 00 00", gnt_w[0], done_w[0]);
        end
        $display("txn reset+write port0 addr=05 data=BEEF");
    endtask

    task automatic test_read_lat3();
        req_s[0] = 2'b10; we_s[0] = 2'b00; a1_s[0] = 6'h3F;
        m_last[0] = 1;
        for (int c = 1; c <= RL0; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt_w[0], done_w[0], ram_we_w[0], ram_re_w[0], ram_a_w[0]} !== {2'b10, 2'b00, 1'b0, 1'b1, 6'h3F}) begin
                n_bad++;
                $display("FAIL read3_access c=%0d got gnt=%b done=%b we=%b re=%b addr=%h exp 10 00 0 1 3F",
                         c, gnt_w[0], done_w[0], ram_we_w[0], ram_re_w[0], ram_a_w[0]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done_w[0], ram_re_w[0], rdata_w[0]} !== {2'b10, 1'b0, m_mem[0][63]}) begin
            n_bad++;
            $display("FAIL read3_done got done=%b re=%b rdata=%h exp 10 0 %h",
                     done_w[0], ram_re_w[0], rdata_w[0], m_mem[0][63]);
        end
        req_s[0] = 2'b00;
        m_rdata[0] = m_mem[0][63];
        @(negedge clk);
        $display("txn read port1 addr=3F rdata=%h", rdata_w[0]);
    endtask

    task automatic test_contention();
        for (int k = 0; k < 2; k++) begin
            logic [1:0] prev_g = 2'b00;
            int got = 0;
            logic [5:0] xa0 = 6'($urandom_range(0, 31));
            logic [5:0] xa1 = 6'($urandom_range(32, 63));
            logic [15:0] xw0 = 16'($urandom_range(0, 16'hFFFE));
            logic [15:0] xw1 = 16'($urandom_range(0, 16'hFFFE));
            we_s[k] = 2'b11; a0_s[k] = xa0; a1_s[k] = xa1; w0_s[k] = xw0; w1_s[k] = xw1;
            req_s[k] = 2'b11;
            for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
                @(negedge clk);
                if (gnt_w[k] != 2'b00 && prev_g == 2'b00) begin
                    int e = pick(k, 2'b11);
                    n_cmp++;
                    if (gnt_w[k] !== oh(e)) begin
                        n_bad++;
                        $display("FAIL contention k=%0d grant#%0d got %b exp %b", k, got, gnt_w[k], oh(e));
                    end
                    $display("txn contention k=%0d grant#%0d gnt=%b", k, got, gnt_w[k]);
                    m_last[k] = e;
                    m_mem[k][(e == 1) ? xa1 : xa0] = (e == 1) ? xw1 : xw0;
                    got++;
                    if (got == 6) req_s[k] = 2'b00;
                end
                prev_g = gnt_w[k];
            end
            n_cmp++;
            if (got != 6) begin
                n_bad++;
                $display("FAIL contention_count k=%0d got %0d grants exp 6", k, got);
            end
            req_s[k] = 2'b00;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_bus_ownership();
        logic [5:0] x = 6'($urandom_range(0, 63));
        for (int i = 0; i < 3; i++) begin
            logic [15:0] wd = (i == 0) ? 16'hA5A5 : 16'($urandom_range(0, 16'hFFFE));
            for (int op = 0; op < 2; op++) begin
                int seen = 0;
                int wcyc = 0;
                req_s[0] = (op == 0) ? 2'b01 : 2'b10;
                we_s[0] = (op == 0) ? 2'b01 : 2'b00;
                a0_s[0] = x; a1_s[0] = x; w0_s[0] = wd;
                m_last[0] = op;
                for (int c = 1; c <= 8 && seen == 0; c++) begin
                    @(negedge clk);
                    if (ram_we_w[0]) begin
                        wcyc++;
                        n_cmp++;
                        if (bus0 !== wd) begin
                            n_bad++;
                            $display("FAIL bus_write i=%0d got %h exp %h", i, bus0, wd);
                        end
                    end else if (!ram_re_w[0]) begin
                        n_cmp++;
                        if (bus0 !== 16'hFFFF) begin
                            n_bad++;
                            $display("FAIL bus_idle i=%0d op=%0d c=%0d got %h exp undriven(FFFF)", i, op, c, bus0);
                        end
                    end
                    if (done_w[0] != 2'b00) seen = c;
                end
                req_s[0] = 2'b00;
                n_cmp++;
                if (seen != ((op == 0) ? 2 : RL0 + 1) || wcyc != ((op == 0) ? 1 : 0)) begin
                    n_bad++;
                    $display("FAIL bus_timing i=%0d op=%0d got done@%0d wcycles=%0d", i, op, seen, wcyc);
                end
                if (op == 1) begin
                    n_cmp++;
                    if (rdata_w[0] !== wd) begin
                        n_bad++;
                        $display("FAIL bus_readback i=%0d got %h exp %h", i, rdata_w[0], wd);
                    end
                    m_rdata[0] = wd;
                end else begin
                    m_mem[0][x] = wd;
                end
                $display("txn bus i=%0d op=%s addr=%h data=%h", i, (op == 0) ? "wr" : "rd", x, wd);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [5:0] p = 6'($urandom_range(0, 63));
        logic [5:0] q = 6'($urandom_range(0, 63));
        int seen = 0;
        int dcount = 0;
        req_s[1] = 2'b10; we_s[1] = 2'b00; a1_s[1] = p;
        for (int c = 1; c <= 8 && seen == 0; c++) begin
            @(negedge clk);
            if (done_w[1] != 2'b00) seen = c;
        end
        req_s[1] = 2'b00;
        n_cmp++;
        if (seen != RL1 + 1 || rdata_w[1] !== m_mem[1][p]) begin
            n_bad++;
            $display("FAIL prime_read got done@%0d rdata=%h exp done@%0d rdata=%h", seen, rdata_w[1], RL1 + 1, m_mem[1][p]);
        end
        @(negedge clk);
        req_s[1] = 2'b01; we_s[1] = 2'b00; a0_s[1] = q;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (ram_re_w[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL midread_pre got re=%b exp 1", ram_re_w[1]);
        end
        rst_s[1] = 1'b0;
        #1;
        n_cmp++;
        if ({gnt_w[1], done_w[1], ram_we_w[1], ram_re_w[1], rdata_w[1]} !== 22'h0) begin
            n_bad++;
            $display("FAIL midread_reset got gnt=%b done=%b we=%b re=%b rdata=%h exp all 0",
                     gnt_w[1], done_w[1], ram_we_w[1], ram_re_w[1], rdata_w[1]);
        end
        n_cmp++;
        if (bus1 !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL midread_bus got %h exp undriven(FFFF)", bus1);
        end
        req_s[1] = 2'b00;
        m_last[1] = 1; m_rdata[1] = 16'h0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done_w[1] != 2'b00) dcount++;
        end
        rst_s[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done_w[1] != 2'b00) dcount++;
        end
        n_cmp++;
        if (dcount != 0) begin
            n_bad++;
            $display("FAIL midread_no_done got %0d done pulses exp 0", dcount);
        end
        req_s[1] = 2'b01; we_s[1] = 2'b00; a0_s[1] = q;
        seen = 0;
        for (int c = 1; c <= 8 && seen == 0; c++) begin
            @(negedge clk);
            if (done_w[1] != 2'b00) seen = c;
        end
        req_s[1] = 2'b00;
        n_cmp++;
        if (seen != RL1 + 1 || done_w[1] !== 2'b01 || rdata_w[1] !== m_mem[1][q]) begin
            n_bad++;
            $display("FAIL midread_recover got done@%0d done=%b rdata=%h exp done@%0d 01 %h",
                     seen, done_w[1], rdata_w[1], RL1 + 1, m_mem[1][q]);
        end
        m_rdata[1] = m_mem[1][q]; m_last[1] = 0;
        $display("txn reset mid-read then read port0 addr=%h rdata=%h", q, rdata_w[1]);
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        logic [5:0] r = 6'($urandom_range(0, 63));
        logic [15:0] d = 16'($urandom_range(0, 16'hFFFE));
        int dn = 0;
        int gr = 0;
        logic [1:0] prev_g = 2'b00;
        req_s[0] = 2'b10; we_s[0] = 2'b10; a1_s[0] = r; w1_s[0] = d;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_s[0] = 2'b00;
            if (done_w[0] == 2'b10) dn++;
            if (gnt_w[0] != 2'b00 && prev_g == 2'b00) gr++;
            prev_g = gnt_w[0];
        end
        n_cmp++;
        if (dn != 1 || gr != 1) begin
            n_bad++;
            $display("FAIL drop_req got done=%0d grants=%0d exp 1 1", dn, gr);
        end
        m_mem[0][r] = d; m_last[0] = 1;
        $display("txn drop-req write port1 addr=%h data=%h", r, d);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int k = $urandom_range(0, 1);
            logic [1:0] mask = 2'($urandom_range(1, 3));
            logic [1:0] wv = 2'($urandom_range(0, 3));
            logic [5:0] x0 = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom_range(0, 63));
            logic [5:0] x1 = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom_range(0, 63));
            logic [15:0] d0 = 16'($urandom_range(0, 16'hFFFE));
            logic [15:0] d1 = 16'($urandom_range(0, 16'hFFFE));
            bit drop = ($urandom_range(0, 3) == 0);
            int w = pick(k, mask);
            bit isw = wv[w];
            int lat = isw ? 1 : rl(k);
            logic [5:0] ea = (w == 1) ? x1 : x0;
            logic [15:0] ed = (w == 1) ? d1 : d0;
            req_s[k] = mask; we_s[k] = wv; a0_s[k] = x0; a1_s[k] = x1; w0_s[k] = d0; w1_s[k] = d1;
            m_last[k] = w;
            for (int c = 1; c <= lat + 1; c++) begin
                logic [5:0] ectl;
                @(negedge clk);
                if (c == 1 && drop) req_s[k] = 2'b00;
                ectl = {oh(w), (c == lat + 1) ? oh(w) : 2'b00, (c <= lat) && isw, (c <= lat) && !isw};
                n_cmp++;
                if ({gnt_w[k], done_w[k], ram_we_w[k], ram_re_w[k]} !== ectl) begin
                    n_bad++;
                    $display("FAIL rand_ctl n=%0d k=%0d c=%0d got %b exp %b", n, k, c,
                             {gnt_w[k], done_w[k], ram_we_w[k], ram_re_w[k]}, ectl);
                end
                if (c <= lat) begin
                    n_cmp++;
                    if (ram_a_w[k] !== ea) begin
                        n_bad++;
                        $display("FAIL rand_addr n=%0d k=%0d c=%0d got %h exp %h", n, k, c, ram_a_w[k], ea);
                    end
                end
                if (c == 1 && isw) begin
                    n_cmp++;
                    if (bus_v[k] !== ed) begin
                        n_bad++;
                        $display("FAIL rand_wbus n=%0d k=%0d got %h exp %h", n, k, bus_v[k], ed);
                    end
                end
                if (c == lat + 1) begin
                    if (isw) m_mem[k][ea] = ed;
                    else m_rdata[k] = m_mem[k][ea];
                    n_cmp++;
                    if (rdata_w[k] !== m_rdata[k] || bus_v[k] !== 16'hFFFF) begin
                        n_bad++;
                        $display("FAIL rand_done n=%0d k=%0d got rdata=%h bus=%h exp %h FFFF",
                                 n, k, rdata_w[k], bus_v[k], m_rdata[k]);
                    end
                    req_s[k] = 2'b00;
                end
            end
            @(negedge clk);
            n_cmp++;
            if ({gnt_w[k], done_w[k]} !== 4'b0000) begin
                n_bad++;
                $display("FAIL rand_idle n=%0d k=%0d got gnt=%b done=%b exp 00 00", n, k, gnt_w[k], done_w[k]);
            end
            $display("txn rand n=%0d k=%0d port=%0d %s addr=%h data=%h", n, k, w, isw ? "wr" : "rd",
                     ea, isw ? ed : m_rdata[k]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 64; a++) m_mem[k][a] = init_word(6'(a));
            m_last[k] = 1;
            m_rdata[k] = 16'h0000;
        end
        test_reset();
        test_read_lat3();
        test_contention();
        test_bus_ownership();
        test_reset_mid_read();
        test_drop_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
